uart_tx: RTL and testbench

//  Serial UART transmitter (8N1 by default), the transmit counterpart of the transceiver's uart_rx.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART encodings. Holds the FSM state codes and the
//                serial line levels used by both uart_tx and uart_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Bit-period counter. Asserts tick on the last cycle of each
//                serial bit. A clear restarts the period so the next bit is
//                full length.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter, LSB first, 8N1 by default. Define
//                UART_TX_PARITY_EN to insert a parity bit before the stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_W       = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              ready,
    output logic              q,
    output logic              active,
    output logic              done
);

    import uart_pkg::*;

    localparam int               c_bit_w    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_W - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    uart_state_t        r_state;
    uart_state_t        w_state_next;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_next;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic [c_bit_w-1:0] w_bit_cnt_next;
    logic               r_q;
    logic               w_q_next;
    logic               w_accept;
    logic               w_tick;

`ifdef UART_TX_PARITY_EN
    localparam logic c_parity_odd = (PARITY_ODD != 0);
    logic r_parity;

    // Parity is taken from the byte at accept time, since the shifter is consumed by then.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= (^data_in) ^ c_parity_odd;
        end
    end
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_accept),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_accept       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en && data_valid) begin
                    w_accept       = 1'b1;
                    w_state_next   = ST_START;
                    w_shift_next   = data_in;
                    w_bit_cnt_next = '0;
                end
            end
            ST_START: begin
                if (w_tick) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == c_bit_last) begin
                        w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next   = ST_PARITY;
`else
                        w_state_next   = ST_STOP;
`endif
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) w_state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_tick) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Line level is derived from the upcoming state so q changes on the same edge as the FSM.
    always_comb begin
        w_q_next = LINE_IDLE;
        case (w_state_next)
            ST_START: w_q_next = START_BIT;
            ST_DATA:  w_q_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_q_next = r_parity;
`endif
            ST_STOP:  w_q_next = STOP_BIT;
            default:  w_q_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_q       <= LINE_IDLE;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_q       <= w_q_next;
        end
    end

    assign ready  = (r_state == ST_IDLE);
    assign active = (r_state != ST_IDLE);
    assign done   = (r_state == ST_STOP) && w_tick;
    assign q      = r_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx (CLKS_PER_BIT=4, DATA_W=8).
//                Expected line activity is built from the frame format.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB  = 4;
    localparam int DW   = 8;
    localparam int PODD = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          ready;
    logic          q;
    logic          active;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    logic exp_q[$];
    logic exp_rdy[$];
    logic exp_done[$];

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data_in    (data_in),
        .data_valid (data_valid),
        .ready      (ready),
        .q          (q),
        .active     (active),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Frame = start, data LSB first, optional parity, stop; each bit CPB cycles.
    task automatic push_frame(input logic [DW-1:0] b);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back((^b) ^ PODD[0]);
`endif
        bits.push_back(1'b1);
        for (int k = 0; k < bits.size(); k++) begin
            for (int c = 0; c < CPB; c++) begin
                exp_q.push_back(bits[k]);
                exp_rdy.push_back(1'b0);
                exp_done.push_back((k == bits.size() - 1) && (c == CPB - 1));
            end
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(1'b1);
            exp_rdy.push_back(1'b1);
            exp_done.push_back(1'b0);
        end
    endtask

    task automatic run_expect(input string tag, input int drop_dv_at, input int drop_en_at);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s_q[%0d]", tag, i), q, exp_q[i]);
            check($sformatf("%s_ready[%0d]", tag, i), ready, exp_rdy[i]);
            check($sformatf("%s_active[%0d]", tag, i), active, !exp_rdy[i]);
            check($sformatf("%s_done[%0d]", tag, i), done, exp_done[i]);
            if (i == drop_dv_at) data_valid = 1'b0;
            if (i == drop_en_at) en = 1'b0;
            if (!data_valid) data_in = DW'($urandom);
        end
        exp_q.delete();
        exp_rdy.delete();
        exp_done.delete();
    endtask

    task automatic send_frame(input string tag, input logic [DW-1:0] b, input int drop_en_at);
        data_in    = b;
        data_valid = 1'b1;
        en         = 1'b1;
        @(negedge clk);
        check({tag, "_pre_ready"}, ready, 1'b1);
        next_cycle();
        push_frame(b);
        push_idle(1);
        run_expect(tag, 0, drop_en_at);
        next_cycle();
        en = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_q", q, 1'b1);
            check("reset_ready", ready, 1'b1);
            check("reset_active", active, 1'b0);
            check("reset_done", done, 1'b0);
        end
        rst = 1'b0;
        en  = 1'b1;
        next_cycle();
        push_idle(5);
        run_expect("post_reset_idle", -1, -1);
        next_cycle();

        send_frame("a5", 8'hA5, -1);
        send_frame("07", 8'h07, -1);

        // Back-to-back with data_valid held: 0x00 then 0xFF.
        data_in    = 8'h00;
        data_valid = 1'b1;
        en         = 1'b1;
        next_cycle();
        data_in = 8'hFF;
        push_frame(8'h00);
        push_idle(1);
        push_frame(8'hFF);
        push_idle(2);
        run_expect("b2b", 45, -1);
        next_cycle();

        // Enable low blocks acceptance.
        en         = 1'b0;
        data_valid = 1'b1;
        data_in    = DW'($urandom);
        push_idle(12);
        run_expect("en_off", 11, -1);
        next_cycle();
        en = 1'b1;

        send_frame("en_drop", 8'h5A, 10);

        // Reset partway through a 0x3C frame.
        data_in    = 8'h3C;
        data_valid = 1'b1;
        en         = 1'b1;
        next_cycle();
        push_frame(8'h3C);
        while (exp_q.size() > 15) begin
            void'(exp_q.pop_back());
            void'(exp_rdy.pop_back());
            void'(exp_done.pop_back());
        end
        run_expect("rst_mid", 0, -1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_q", q, 1'b1);
        check("rst_mid_ready", ready, 1'b1);
        check("rst_mid_active", active, 1'b0);
        check("rst_mid_done", done, 1'b0);
        rst = 1'b0;
        next_cycle();
        send_frame("after_rst", 8'h3C, -1);

        for (int r = 0; r < 10; r++) begin
            logic [DW-1:0] b;
            int            drop;
            b    = DW'($urandom);
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : -1;
            send_frame($sformatf("rand%0d", r), b, drop);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
